// File: rtl/p_ctx_store_if.sv
// Bus bundle for p_ctx_store: external PD/PN access, input mux control, flags
// and copy-engine handshake.
interface p_ctx_store_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5,
  parameter int CTX_W  = 1
);
  logic [CTX_W-1:0]  ctx;
  logic [ADDR_W-1:0] PD_addr;
  logic              PD_wr_en;
  logic [WIDTH-1:0]  PD_out;
  logic [WIDTH-1:0]  din;
  logic [WIDTH-1:0]  Ltmp_in;
  logic [1:0]        input_sel;
  logic [ADDR_W-1:0] PN_wr_addr;
  logic [ADDR_W-1:0] PN_addr;
  logic              PN_wr_en;
  logic [WIDTH-1:0]  PN_out;
  logic [WIDTH-1:0]  S_input;
  logic              ZF_wr_en;
  logic              ZF;
  logic              B31;
  logic              copy_start;
  logic              copy_busy;
  logic              copy_done;

  modport slave (
    input  ctx, PD_addr, PD_wr_en, din, Ltmp_in, input_sel, PN_wr_addr,
           PN_addr, PN_wr_en, ZF_wr_en, copy_start,
    output PD_out, PN_out, S_input, ZF, B31, copy_busy, copy_done
  );

  modport master (
    output ctx, PD_addr, PD_wr_en, din, Ltmp_in, input_sel, PN_wr_addr,
           PN_addr, PN_wr_en, ZF_wr_en, copy_start,
    input  PD_out, PN_out, S_input, ZF, B31, copy_busy, copy_done
  );
endinterface

// File: rtl/p_ctx_store.sv
// Per-context PD (constant) / PN (working) storage for interleaved bcrypt
// contexts, with input mux, counter decrement, flags and an EK copy engine.
module p_ctx_store #(
  parameter int WIDTH       = 32,
  parameter int ADDR_W      = 5,
  parameter int NUM_CTX     = 2,
  parameter int CTX_W       = 1,
  parameter int EK_WORDS    = 18,
  parameter int SETTING_MAX = 4
) (
  input  logic          CLK,
  input  logic          RESET_N,
  p_ctx_store_if.slave  bus
);
  localparam int IW    = CTX_W + ADDR_W;
  localparam int MEM_D = 1 << IW;

  typedef enum logic [1:0] {IDLE, COPY, DONE} state_t;

  state_t            state, state_nx;
  logic [CTX_W-1:0]  cctx, cctx_nx;
  logic [ADDR_W-1:0] cnt, cnt_nx;

  logic [WIDTH-1:0] pd_mem [MEM_D];
  logic [WIDTH-1:0] pn_mem [MEM_D];

  logic [CTX_W-1:0]       ctx_m;
  logic [IW-1:0]          pd_a, pn_ra, pn_wa, cp_a;
  logic                   busy, copy_we;
  logic [SETTING_MAX:0]   dec_f;
  logic [WIDTH-1:0]       pn_input;
  logic                   zf_q, b31_q;

  // A single-context build has no context select; pin the index to 0.
  assign ctx_m = (NUM_CTX == 1) ? '0 : bus.ctx;
  assign pd_a  = {ctx_m, bus.PD_addr};
  assign pn_ra = {ctx_m, bus.PN_addr};
  assign pn_wa = {ctx_m, bus.PN_wr_addr};
  assign cp_a  = {cctx, cnt};

  assign busy    = (state != IDLE);
  assign copy_we = (state == COPY);

  assign bus.PD_out = pd_mem[pd_a];
  assign bus.PN_out = pn_mem[pn_ra];

  assign dec_f = bus.PN_out[SETTING_MAX:0] - (SETTING_MAX+1)'(1);

  always_comb begin
    pn_input = bus.din;
    case (bus.input_sel)
      2'd0:    pn_input = bus.din;
      2'd1:    pn_input = bus.Ltmp_in;
      default: pn_input = {{(WIDTH-SETTING_MAX-1){1'b0}}, dec_f};
    endcase
  end

  assign bus.S_input = pn_input;

  // Storage is not reset; external writes are locked out while copying.
  always_ff @(posedge CLK) begin
    if (bus.PD_wr_en && !busy) pd_mem[pd_a] <= bus.din;
  end

  always_ff @(posedge CLK) begin
    if (copy_we)                   pn_mem[cp_a]  <= pd_mem[cp_a];
    else if (bus.PN_wr_en && !busy) pn_mem[pn_wa] <= pn_input;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      zf_q  <= 1'b0;
      b31_q <= 1'b0;
    end else if (bus.ZF_wr_en) begin
      zf_q  <= (pn_input[WIDTH-2:0] == '0);
      b31_q <= bus.PD_out[WIDTH-1];
    end
  end

  assign bus.ZF  = zf_q;
  assign bus.B31 = b31_q;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= IDLE;
      cctx  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cctx  <= cctx_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cctx_nx  = cctx;
    cnt_nx   = cnt;
    case (state)
      IDLE: if (bus.copy_start) begin
        state_nx = COPY;
        cctx_nx  = ctx_m;
        cnt_nx   = '0;
      end
      COPY: begin
        cnt_nx = cnt + 1'b1;
        if (cnt == ADDR_W'(EK_WORDS-1)) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign bus.copy_busy = busy;
  assign bus.copy_done = (state == DONE);
endmodule
